// File: rtl/sd_cmd_tx_if.sv
// Command-frame request/status bundle between command-issue logic and sd_cmd_tx.
// master = issuer (drives request and bit-rate enable), slave = serializer.
interface sd_cmd_tx_if;
    logic        CE;
    logic        START;
    logic [5:0]  CMD_INDEX;
    logic [31:0] ARG;
    logic        READY;
    logic        CMD_OUT;
    logic        CMD_OE;
    logic        DONE;
    logic [6:0]  CRC_OUT;

    modport master (
        output CE, START, CMD_INDEX, ARG,
        input  READY, CMD_OUT, CMD_OE, DONE, CRC_OUT
    );

    modport slave (
        input  CE, START, CMD_INDEX, ARG,
        output READY, CMD_OUT, CMD_OE, DONE, CRC_OUT
    );
endinterface

// File: rtl/sd_cmd_tx.sv
// SD CMD-line serializer: 48-bit frame (start, dir, index, arg, CRC7, end), MSB first, one bit per CE.
// Latency: start bit driven the cycle after acceptance; DONE 48 CE-edges after acceptance.
// Backpressure: READY low from acceptance until frame (and, with SD_CMD_TX_GAP_EN, the N_CC gap) ends.
module sd_cmd_tx #(
    parameter int GAP_BITS = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    sd_cmd_tx_if.slave bus
);

    // Counter covers 40 data bits and, when enabled, the gap length.
    localparam int CNT_W = (GAP_BITS > 63) ? $clog2(GAP_BITS + 1) : 6;
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(39);
    localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(6);
`ifdef SD_CMD_TX_GAP_EN
    // The IDLE cycle in which the next START is taken supplies the last idle bit,
    // so GAP itself spans GAP_BITS-1 CE-cycles (GAP_BITS must be at least 2).
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_BITS > 2) ? GAP_BITS - 2 : 0);
`endif

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_CRC  = 3'd2,
`ifdef SD_CMD_TX_GAP_EN
        ST_END  = 3'd3,
        ST_GAP  = 3'd4
`else
        ST_END  = 3'd3
`endif
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [39:0]      shift_q;
    logic [39:0]      shift_d;
    logic [6:0]       crc_q;
    logic [6:0]       crc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic             crc_inv;
    logic [6:0]       crc_step;

    logic             ready_q;
    logic             ready_d;
    logic             cmd_out_q;
    logic             cmd_out_d;
    logic             cmd_oe_q;
    logic             cmd_oe_d;
    logic             done_q;
    logic             done_d;
    logic [6:0]       crc_out_q;
    logic [6:0]       crc_out_d;

    // x^7 + x^3 + 1, serial form fed with the bit currently on the line
    assign crc_inv  = shift_q[39] ^ crc_q[6];
    assign crc_step = {crc_q[5:3], crc_q[2] ^ crc_inv, crc_q[1:0], crc_inv};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.CE && (cnt_q == DATA_LAST)) begin
                    state_d = ST_CRC;
                end
            end
            ST_CRC: begin
                if (bus.CE && (cnt_q == CRC_LAST)) begin
                    state_d = ST_END;
                end
            end
            ST_END: begin
                if (bus.CE) begin
`ifdef SD_CMD_TX_GAP_EN
                    state_d = ST_GAP;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef SD_CMD_TX_GAP_EN
            ST_GAP: begin
                if (bus.CE && (cnt_q == GAP_LAST)) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_d = shift_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    shift_d = {1'b0, 1'b1, bus.CMD_INDEX, bus.ARG};
                    crc_d   = 7'd0;
                    cnt_d   = '0;
                end
            end
            ST_DATA: begin
                if (bus.CE) begin
                    crc_d   = crc_step;
                    shift_d = {shift_q[38:0], 1'b0};
                    cnt_d   = (cnt_q == DATA_LAST) ? '0 : cnt_q + 1'b1;
                end
            end
            ST_CRC: begin
                if (bus.CE) begin
                    crc_d = {crc_q[5:0], 1'b0};
                    cnt_d = (cnt_q == CRC_LAST) ? '0 : cnt_q + 1'b1;
                end
            end
`ifdef SD_CMD_TX_GAP_EN
            ST_GAP: begin
                if (bus.CE) begin
                    cnt_d = (cnt_q == GAP_LAST) ? '0 : cnt_q + 1'b1;
                end
            end
`endif
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shift_q <= '0;
            crc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output values are computed for the state being entered and then registered,
    // so the pad sees clean flop outputs aligned with the state.
    always_comb begin
        ready_d   = (state_d == ST_IDLE);
        cmd_oe_d  = (state_d == ST_DATA) || (state_d == ST_CRC) || (state_d == ST_END);
        cmd_out_d = 1'b1;
        if (state_d == ST_DATA) begin
            cmd_out_d = shift_d[39];
        end else if (state_d == ST_CRC) begin
            cmd_out_d = crc_d[6];
        end
        done_d    = (state_q == ST_END) && bus.CE;
        crc_out_d = crc_out_q;
        if ((state_q == ST_DATA) && (state_d == ST_CRC)) begin
            crc_out_d = crc_step;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ready_q   <= 1'b1;
            cmd_out_q <= 1'b1;
            cmd_oe_q  <= 1'b0;
            done_q    <= 1'b0;
            crc_out_q <= 7'd0;
        end else begin
            ready_q   <= ready_d;
            cmd_out_q <= cmd_out_d;
            cmd_oe_q  <= cmd_oe_d;
            done_q    <= done_d;
            crc_out_q <= crc_out_d;
        end
    end

    assign bus.READY   = ready_q;
    assign bus.CMD_OUT = cmd_out_q;
    assign bus.CMD_OE  = cmd_oe_q;
    assign bus.DONE    = done_q;
    assign bus.CRC_OUT = crc_out_q;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Directed bench for sd_cmd_tx: known SD command frames, CE stalls, busy START and mid-frame reset.
module tb_sd_cmd_tx;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;

    sd_cmd_tx_if bus ();

    sd_cmd_tx #(.GAP_BITS(8)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

`ifdef SD_CMD_TX_GAP_EN
    localparam logic READY_AT_DONE = 1'b0;
`else
    localparam logic READY_AT_DONE = 1'b1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 100 && bus.READY !== 1'b1; i++) @(negedge CLK);
        check({tag, "_ready"}, bus.READY, 1'b1);
    endtask

    // Sends one frame; poke_at >= 0 re-asserts START (CMD8) at that cycle to prove it is ignored.
    task automatic send_frame(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                              input bit toggle, input int poke_at, input logic [47:0] exp_frame,
                              input logic [6:0] exp_crc, input int exp_done);
        logic [47:0] cap;
        int          nbits;
        int          done_n;
        logic        ce_next;
        logic        rdy_at_done;
        logic        oe_at_done;
        cap    = '0;
        nbits  = 0;
        done_n = -1;
        rdy_at_done = 1'b0;
        oe_at_done  = 1'b1;
        wait_ready(tag);
        @(negedge CLK);
        bus.START     = 1'b1;
        bus.CMD_INDEX = idx;
        bus.ARG       = arg;
        bus.CE        = 1'b1;
        @(negedge CLK);
        bus.START     = 1'b0;
        bus.CMD_INDEX = 6'h3F;
        bus.ARG       = 32'hFFFF_FFFF;
        check({tag, "_first_bit"}, {bus.READY, bus.CMD_OE, bus.CMD_OUT}, 3'b010);
        for (int n = 0; n < 300 && done_n < 0; n++) begin
            if (n > 0) @(negedge CLK);
            if (bus.DONE === 1'b1) begin
                done_n      = n;
                rdy_at_done = bus.READY;
                oe_at_done  = bus.CMD_OE;
            end else begin
                ce_next = toggle ? logic'(n % 2 == 1) : 1'b1;
                if (n == poke_at) begin
                    bus.START     = 1'b1;
                    bus.CMD_INDEX = 6'd8;
                    check({tag, "_busy"}, bus.READY, 1'b0);
                end else begin
                    bus.START = 1'b0;
                end
                bus.CE = ce_next;
                if (ce_next && bus.CMD_OE === 1'b1) begin
                    cap = {cap[46:0], bus.CMD_OUT};
                    nbits++;
                end
            end
        end
        bus.START = 1'b0;
        bus.CE    = 1'b1;
        check({tag, "_done_cycle"}, done_n, exp_done);
        check({tag, "_nbits"}, nbits, 48);
        check({tag, "_frame"}, cap, exp_frame);
        check({tag, "_crc"}, bus.CRC_OUT, exp_crc);
        check({tag, "_ready_at_done"}, rdy_at_done, READY_AT_DONE);
        check({tag, "_oe_at_done"}, oe_at_done, 1'b0);
        @(negedge CLK);
        check({tag, "_done_pulse"}, bus.DONE, 1'b0);
        check({tag, "_crc_hold"}, bus.CRC_OUT, exp_crc);
    endtask

    task automatic reset_abort();
        logic seen_done;
        seen_done = 1'b0;
        wait_ready("abort");
        @(negedge CLK);
        bus.START     = 1'b1;
        bus.CMD_INDEX = 6'd0;
        bus.ARG       = 32'h0;
        bus.CE        = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        repeat (20) @(negedge CLK);
        check("abort_midframe_oe", bus.CMD_OE, 1'b1);
        RST_N = 1'b0;
        #1;
        check("abort_oe", bus.CMD_OE, 1'b0);
        check("abort_out", bus.CMD_OUT, 1'b1);
        check("abort_ready", bus.READY, 1'b1);
        check("abort_crc", bus.CRC_OUT, 7'h00);
        repeat (3) begin
            @(negedge CLK);
            if (bus.DONE === 1'b1) seen_done = 1'b1;
        end
        RST_N = 1'b1;
        repeat (60) begin
            @(negedge CLK);
            if (bus.DONE === 1'b1) seen_done = 1'b1;
        end
        check("abort_no_done", seen_done, 1'b0);
        check("abort_idle_oe", bus.CMD_OE, 1'b0);
    endtask

`ifdef SD_CMD_TX_GAP_EN
    task automatic gap_b2b();
        int gap;
        int guard;
        gap   = 0;
        guard = 0;
        wait_ready("gap");
        @(negedge CLK);
        bus.START     = 1'b1;
        bus.CMD_INDEX = 6'd0;
        bus.ARG       = 32'h0;
        bus.CE        = 1'b1;
        while (bus.DONE !== 1'b1 && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        check("gap_done_seen", bus.DONE, 1'b1);
        while (bus.CMD_OE !== 1'b1 && gap < 50) begin
            gap++;
            @(negedge CLK);
        end
        bus.START = 1'b0;
        check("gap_len", gap, 8);
        check("gap_next_start_bit", bus.CMD_OUT, 1'b0);
        guard = 0;
        while (bus.DONE !== 1'b1 && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        check("gap_second_done", bus.DONE, 1'b1);
    endtask
`endif

    initial begin
        bus.CE        = 1'b0;
        bus.START     = 1'b0;
        bus.CMD_INDEX = 6'd0;
        bus.ARG       = 32'h0;
        repeat (2) @(negedge CLK);
        check("rst_ready", bus.READY, 1'b1);
        check("rst_out", bus.CMD_OUT, 1'b1);
        check("rst_oe", bus.CMD_OE, 1'b0);
        check("rst_done", bus.DONE, 1'b0);
        check("rst_crc", bus.CRC_OUT, 7'h00);
        RST_N = 1'b1;
        @(negedge CLK);

        send_frame("cmd0",   6'd0,  32'h0000_0000, 1'b0, -1, 48'h40_0000_0000_95, 7'h4A, 48);
        send_frame("cmd8",   6'd8,  32'h0000_01AA, 1'b0, -1, 48'h48_0000_01AA_87, 7'h43, 48);
        send_frame("cmd17",  6'd17, 32'h0000_0000, 1'b1, -1, 48'h51_0000_0000_55, 7'h2A, 96);
        send_frame("cmd55",  6'd55, 32'h0000_0000, 1'b0, -1, 48'h77_0000_0000_65, 7'h32, 48);
        send_frame("acmd41", 6'd41, 32'h4000_0000, 1'b0, -1, 48'h69_4000_0000_77, 7'h3B, 48);
        send_frame("busy",   6'd0,  32'h0000_0000, 1'b0, 10, 48'h40_0000_0000_95, 7'h4A, 48);
        reset_abort();
        send_frame("post_rst", 6'd0, 32'h0000_0000, 1'b0, -1, 48'h40_0000_0000_95, 7'h4A, 48);
`ifdef SD_CMD_TX_GAP_EN
        gap_b2b();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_cmd_tx.md
Name: sd_cmd_tx

Overview:
- Serializer for SD-bus command frames, placed directly downstream of the command-issue logic and in front of the CMD line pad.
- Takes a 6-bit command index and a 32-bit argument, then builds the 48-bit frame: start bit, transmission bit, index, argument, CRC7, end bit.
- Drives the frame MSB-first, one bit per bit-rate enable.
- Computes CRC7 inline over the first 40 frame bits, using the same polynomial and shift form as sd_crc_7 (x^7+x^3+1, inv = bit ^ crc[6]).

Parameters:
GAP_BITS, 8, idle CE-cycles of CMD high after the end bit (N_CC); used only when SD_CMD_TX_GAP_EN is defined.

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
CE  input  1  bit-rate enable; the frame advances one bit per CLK edge with CE=1
START  input  1  request; accepted on a CLK edge with START=1 and READY=1
CMD_INDEX  input  6  command index, sampled at acceptance
ARG  input  32  command argument, sampled at acceptance
READY  output  1  block idle and able to accept START
CMD_OUT  output  1  serial CMD line data
CMD_OE  output  1  CMD pad output enable
DONE  output  1  one-CLK pulse after the end bit completes
CRC_OUT  output  7  CRC7 of the last frame sent; holds until the next acceptance

Behaviour:
- Reset is asynchronous and active-low. While RST_N=0: READY=1, CMD_OUT=1, CMD_OE=0, DONE=0, CRC_OUT=0, state=IDLE, counters=0.
- All outputs come from registers. No combinational path from any input to any output.
- States: IDLE, DATA, CRC, END, GAP. GAP exists only when SD_CMD_TX_GAP_EN is defined.
- IDLE: READY=1, CMD_OE=0, CMD_OUT=1.
  - On START=1 (CE not required), load shift register {1'b0, 1'b1, CMD_INDEX, ARG}, clear CRC and bit count, go to DATA.
  - READY=0 from the next cycle onward.
- DATA: CMD_OE=1, CMD_OUT = shift MSB.
  - Each CE=1 edge: update CRC with the current bit, shift left, count+1.
  - After the 40th bit, go to CRC.
- CRC: CMD_OUT = crc[6].
  - Each CE=1 edge: shift crc left with zero fill; the registered CRC_OUT keeps the full value.
  - After 7 bits, go to END.
- END: CMD_OUT=1, CMD_OE=1 for one CE-period. On its CE edge, go to IDLE (or GAP); pulse DONE for that following cycle.
- CE=0 stalls every state except IDLE. Outputs are held.
- Latency with CE tied high: START accepted at edge k, start bit visible after edge k, end bit ends at edge k+48, DONE=1 in cycle k+48.
- START while READY=0 is ignored. No queuing. CMD_INDEX/ARG changes after acceptance have no effect.
- RST_N asserted mid-frame: immediate abort, outputs at reset values. No DONE is emitted for the aborted frame.
- CRC_OUT is updated at entry to CRC state with the 7-bit result.

Optional Feature:
SD_CMD_TX_GAP_EN
- Defined: after END, enter GAP with CMD_OE=0 and CMD_OUT=1 for GAP_BITS CE-cycles.
  - DONE pulses on leaving END as normal.
  - READY rises only when GAP completes, so back-to-back frames keep N_CC spacing.
- Not defined: END returns directly to IDLE, and READY=1 in the same cycle DONE=1.

Test Plan:
- CMD0, ARG=0x00000000, CE=1 -> serial bytes 0x40 00 00 00 00 95; CRC_OUT=0x4A; DONE at cycle 48 after acceptance.
- CMD8, ARG=0x000001AA -> bytes 0x48 00 00 01 AA 87; CRC_OUT=0x43.
- CMD17, ARG=0x00000000, CE toggling 1/0 each cycle -> bytes 0x51 00 00 00 00 55; each bit held 2 CLK; DONE at cycle 96.
- START pulsed again at bit 10 of CMD0 with CMD_INDEX=8 -> ignored; frame still ends 0x95; READY stays 0 until completion.
- RST_N low at bit 20 -> CMD_OE=0 and CMD_OUT=1 immediately; no DONE; after release READY=1 and a new CMD0 yields 0x95.
- With SD_CMD_TX_GAP_EN, GAP_BITS=8, back-to-back START held high -> 8 CE-cycles of CMD_OE=0 between end bit and next start bit.
